// File: rtl/rf_write_sequencer.sv
// Owns the register-file write port: clears registers 1..N-1 after reset, then
// round-robin arbitrates the ALU (A) and load (B) writeback requesters onto it.
//
// state   | meaning
// S_CLEAR | post-reset sweep writing zero to registers 1..2^NAME_BITS-1
// S_ARB   | round-robin arbitration of A/B onto the write port
module rf_write_sequencer #(
  parameter int REG_WIDTH = 32,
  parameter int NAME_BITS = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_a_valid,
  output logic                 o_a_ready,
  input  logic [NAME_BITS-1:0] i_a_ws,
  input  logic [REG_WIDTH-1:0] i_a_wd,
  input  logic                 i_b_valid,
  output logic                 o_b_ready,
  input  logic [NAME_BITS-1:0] i_b_ws,
  input  logic [REG_WIDTH-1:0] i_b_wd,
  output logic                 o_rf_we,
  output logic [NAME_BITS-1:0] o_rf_ws,
  output logic [REG_WIDTH-1:0] o_rf_wd,
  output logic                 o_clear_busy,
  output logic                 o_last_grant
);

  typedef enum logic {S_CLEAR, S_ARB} state_t;

  localparam logic [NAME_BITS-1:0] LAST_REG = '1;

  state_t               r_state;
  logic [NAME_BITS-1:0] r_cnt;
  logic                 r_rf_we;
  logic [NAME_BITS-1:0] r_rf_ws;
  logic [REG_WIDTH-1:0] r_rf_wd;
  logic                 r_clear_busy;
  logic                 r_last_grant;

  logic w_in_arb;
  logic w_a_hs;
  logic w_b_hs;

  // Ties go to whichever requester was not granted most recently.
  assign w_in_arb  = (r_state == S_ARB);
  assign o_a_ready = w_in_arb & i_a_valid & (~i_b_valid | r_last_grant);
  assign o_b_ready = w_in_arb & i_b_valid & (~i_a_valid | ~r_last_grant);
  assign w_a_hs    = i_a_valid & o_a_ready;
  assign w_b_hs    = i_b_valid & o_b_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_CLEAR;
      r_cnt        <= {{(NAME_BITS-1){1'b0}}, 1'b1};
      r_rf_we      <= 1'b0;
      r_rf_ws      <= '0;
      r_rf_wd      <= '0;
      r_clear_busy <= 1'b1;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_rf_we <= 1'b1;
          r_rf_ws <= r_cnt;
          r_rf_wd <= '0;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_REG) begin
            r_state      <= S_ARB;
            r_clear_busy <= 1'b0;
          end
        end
        S_ARB: begin
          // Register 0 is hardwired; its writes complete the handshake but never reach the file.
          if (w_a_hs) begin
            r_rf_we      <= |i_a_ws;
            r_rf_ws      <= i_a_ws;
            r_rf_wd      <= i_a_wd;
            r_last_grant <= 1'b0;
          end else if (w_b_hs) begin
            r_rf_we      <= |i_b_ws;
            r_rf_ws      <= i_b_ws;
            r_rf_wd      <= i_b_wd;
            r_last_grant <= 1'b1;
          end else begin
            r_rf_we <= 1'b0;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign o_rf_we      = r_rf_we;
  assign o_rf_ws      = r_rf_ws;
  assign o_rf_wd      = r_rf_wd;
  assign o_clear_busy = r_clear_busy;
  assign o_last_grant = r_last_grant;

endmodule

// File: tb/tb_rf_write_sequencer.sv
// Bench for rf_write_sequencer: directed scenarios followed by random requester
// traffic, all checked cycle by cycle against a behavioural model.
module tb_rf_write_sequencer;
  localparam int RW    = 32;
  localparam int NB    = 5;
  localparam int NREGS = 1 << NB;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [NB-1:0] a_ws, b_ws;
  logic [RW-1:0] a_wd, b_wd;
  logic          rf_we;
  logic [NB-1:0] rf_ws;
  logic [RW-1:0] rf_wd;
  logic          clear_busy, last_grant;

  always #5 clk = ~clk;

  rf_write_sequencer #(.REG_WIDTH(RW), .NAME_BITS(NB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_ws(a_ws), .i_a_wd(a_wd),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_ws(b_ws), .i_b_wd(b_wd),
    .o_rf_we(rf_we), .o_rf_ws(rf_ws), .o_rf_wd(rf_wd),
    .o_clear_busy(clear_busy), .o_last_grant(last_grant)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: registers still to clear, who was served last, and the write now on the port.
  int            m_sweep_next;   // 0 once the sweep is done
  bit            m_last_b;
  bit            m_we;
  logic [NB-1:0] m_ws;
  logic [RW-1:0] m_wd;
  bit            seen_a_rdy, seen_b_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sweep_next = 1;
    m_last_b     = 1'b1;
    m_we         = 1'b0;
    m_ws         = '0;
    m_wd         = '0;
  endtask

  // One clock: check at the falling edge, advance the model, return 1ns after the rising edge.
  task automatic cycle();
    bit grant_a, grant_b;
    @(negedge clk);
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (m_sweep_next == 0) begin
      if (a_valid && b_valid) begin
        grant_a = m_last_b;
        grant_b = !m_last_b;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
    if (!rst) begin
      chk("a_ready", a_ready, grant_a);
      chk("b_ready", b_ready, grant_b);
    end
    chk("rf_we", rf_we, m_we);
    chk("rf_ws", rf_ws, m_ws);
    chk("rf_wd", rf_wd, m_wd);
    chk("clear_busy", clear_busy, m_sweep_next != 0);
    chk("last_grant", last_grant, m_last_b);
    seen_a_rdy = a_ready;
    seen_b_rdy = b_ready;
    if (rst) begin
      model_reset();
    end else if (m_sweep_next != 0) begin
      m_we = 1'b1;
      m_ws = NB'(m_sweep_next);
      m_wd = '0;
      m_sweep_next = (m_sweep_next == NREGS - 1) ? 0 : m_sweep_next + 1;
    end else if (grant_a) begin
      m_we = (a_ws != 0);
      m_ws = a_ws;
      m_wd = a_wd;
      m_last_b = 1'b0;
    end else if (grant_b) begin
      m_we = (b_ws != 0);
      m_ws = b_ws;
      m_wd = b_wd;
      m_last_b = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_ws = '0; a_wd = '0;
    b_valid = 1'b0; b_ws = '0; b_wd = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    model_reset();

    // Reset state with A already requesting; A must stay blocked through the whole sweep.
    rst = 1'b0;
    a_valid = 1'b1; a_ws = 5'd7; a_wd = 32'h1234;
    chk("reset_we", rf_we, 1'b0);
    chk("reset_busy", clear_busy, 1'b1);
    for (int i = 0; i < NREGS - 2; i++) cycle();
    a_valid = 1'b0;
    cycle();
    chk("sweep_last_ws", rf_ws, 5'd31);
    chk("sweep_last_we", rf_we, 1'b1);
    chk("sweep_done_busy", clear_busy, 1'b0);

    // Continuous contention alternates A,B,A,B starting with A.
    a_valid = 1'b1; a_ws = 5'd3; a_wd = 32'hA;
    b_valid = 1'b1; b_ws = 5'd4; b_wd = 32'hB;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("contend_ws", rf_ws, (i % 2 == 0) ? 5'd3 : 5'd4);
      chk("contend_wd", rf_wd, (i % 2 == 0) ? 32'hA : 32'hB);
    end
    idle_inputs();
    cycle();

    // Single A request.
    a_valid = 1'b1; a_ws = 5'd5; a_wd = 32'hDEADBEEF;
    cycle();
    a_valid = 1'b0;
    chk("single_we", rf_we, 1'b1);
    chk("single_ws", rf_ws, 5'd5);
    chk("single_wd", rf_wd, 32'hDEADBEEF);
    chk("single_last", last_grant, 1'b0);
    cycle();
    chk("single_we_drop", rf_we, 1'b0);

    // Register-0 write from B: handshake completes, no write enable.
    b_valid = 1'b1; b_ws = '0; b_wd = 32'h55;
    cycle();
    b_valid = 1'b0;
    chk("r0_we", rf_we, 1'b0);
    chk("r0_last", last_grant, 1'b1);
    cycle();

    // Reset mid-sweep at rf_ws=10, then a full fresh sweep.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("midsweep_ws", rf_ws, 5'd10);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midsweep_rst_we", rf_we, 1'b0);
    chk("midsweep_rst_ws", rf_ws, 5'd0);
    cycle();
    chk("restart_ws", rf_ws, 5'd1);
    for (int i = 0; i < NREGS - 2; i++) cycle();
    chk("restart_end_ws", rf_ws, 5'd31);
    chk("restart_end_busy", clear_busy, 1'b0);

    // Reset in ARB with A requesting: A waits out the new sweep.
    a_valid = 1'b1; a_ws = 5'd9; a_wd = 32'hCAFE;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("arb_rst_we", rf_we, 1'b0);
    chk("arb_rst_last", last_grant, 1'b1);
    chk("arb_rst_busy", clear_busy, 1'b1);
    for (int i = 0; i < NREGS; i++) cycle();
    chk("arb_rst_accept_ws", rf_ws, 5'd9);
    chk("arb_rst_accept_wd", rf_wd, 32'hCAFE);
    a_valid = 1'b0;
    cycle();

    // Random traffic; requesters hold ws/wd until accepted, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cycle();
      if (!a_valid || seen_a_rdy) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_ws = NB'($urandom);
        a_wd = $urandom;
      end
      if (!b_valid || seen_b_rdy) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_ws = NB'($urandom);
        b_wd = $urandom;
      end
    end
    rst = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
